hazard_stall_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Drives the ID/EX register from the decode side. It decides each cycle whether ID/EX loads a real instruction, loads a bubble (WB/M/EX control forced to zero) or holds.
- Also gates PC and IF/ID writes, flushes IF/ID on taken branches, and freezes the whole pipeline for a fixed-latency data-memory access.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/hazard_detect.sv | 22 ++
 rtl/hazard_stall_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants.
// Used by the hazard/stall controller and the pipeline registers.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MEM_LAT_DEF = 4;

  localparam int WB_W = 2;
  localparam int M_W  = 2;
  localparam int EX_W = 4;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: EX holds a load whose destination
// feeds a source of the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  output logic       lu_o
);

  logic src_hit;

  assign src_hit = (idex_rt_i == ifid_rs_i)
                || (idex_rt_i == ifid_rt_i);

  assign lu_o = memread_i
             && (idex_rt_i != REG_ZERO)
             && src_hit;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller: load-use bubbles, branch flush
// and fixed-latency memory freeze. Optional HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       IDEX_MemRead_i,
  input  logic [4:0] IDEX_rt_i,
  input  logic [4:0] IFID_rs_i,
  input  logic [4:0] IFID_rt_i,
  input  logic       Branch_taken_i,
  input  logic       mem_req_i,
  output logic       PCWrite_o,
  output logic       IFIDWrite_o,
  output logic       IFIDFlush_o,
  output logic       Bubble_o,
  output logic       Freeze_o,
  output logic       mem_done_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] lu_stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] mem_stall_cnt_o
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  hazard_detect u_hd (
    .memread_i (IDEX_MemRead_i),
    .idex_rt_i (IDEX_rt_i),
    .ifid_rs_i (IFID_rs_i),
    .ifid_rt_i (IFID_rt_i),
    .lu_o      (lu)
  );

  // Mealy decode of controls and next state; reset overrides outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    IFIDFlush_o = 1'b0;
    Bubble_o    = 1'b0;
    Freeze_o    = 1'b0;
    mem_done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          Freeze_o    = 1'b1;
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          if (MEM_LAT == 1) begin
            mem_done_o = 1'b1;
          end else begin
            cnt_d   = CNT_W'(MEM_LAT - 2);
            state_d = MEM_WAIT;
          end
        end else if (lu) begin
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          Bubble_o    = 1'b1;
        end else if (Branch_taken_i) begin
          IFIDFlush_o = 1'b1;
        end
      end
      MEM_WAIT: begin
        Freeze_o    = 1'b1;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        if (cnt_q == '0) begin
          mem_done_o = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      IFIDFlush_o = 1'b0;
      Bubble_o    = 1'b1;
      Freeze_o    = 1'b1;
      mem_done_o  = 1'b0;
    end
  end

  // State and latency counter; reset aborts any access in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] fl_cnt_q, fl_cnt_d;
  logic [31:0] ms_cnt_q, ms_cnt_d;

  // Saturating event counters
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    ms_cnt_d = ms_cnt_q;
    if (!rst_i && Bubble_o && lu_cnt_q != '1)
      lu_cnt_d = lu_cnt_q + 32'd1;
    if (IFIDFlush_o && fl_cnt_q != '1)
      fl_cnt_d = fl_cnt_q + 32'd1;
    if (!rst_i && Freeze_o && ms_cnt_q != '1)
      ms_cnt_d = ms_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
      ms_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      ms_cnt_q <= ms_cnt_d;
    end
  end

  assign lu_stall_cnt_o  = lu_cnt_q;
  assign flush_cnt_o     = fl_cnt_q;
  assign mem_stall_cnt_o = ms_cnt_q;
`endif

`ifndef SYNTHESIS
  a_req_in_wait: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(state_q == MEM_WAIT && mem_req_i))
    else $error("mem_req_i asserted during MEM_WAIT");

  a_no_bub_frz: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(Bubble_o && Freeze_o));

  a_pc_ifid: assert property (
    @(posedge clk_i) PCWrite_o == IFIDWrite_o);
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl.
// Vector table, hand sequences and random vs. a behavioural model.
module tb_hazard_stall_ctrl;

  localparam int LAT = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       mr;
  logic [4:0] xrt, rs, rt;
  logic       br, req;

  logic pcw, ifw, fl, bub, frz, dn;
  logic pcw1, ifw1, fl1, bub1, frz1, dn1;
  logic [5:0] out0, out1;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_c, fl_c, ms_c;
  logic [31:0] lu_c1, fl_c1, ms_c1;
`endif

  int checks   = 0;
  int failures = 0;
  int fleft    = 0;

  always #5 clk_i = ~clk_i;

  hazard_stall_ctrl #(.MEM_LAT(LAT), .CNT_W(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (mr),
    .IDEX_rt_i      (xrt),
    .IFID_rs_i      (rs),
    .IFID_rt_i      (rt),
    .Branch_taken_i (br),
    .mem_req_i      (req),
    .PCWrite_o      (pcw),
    .IFIDWrite_o    (ifw),
    .IFIDFlush_o    (fl),
    .Bubble_o       (bub),
    .Freeze_o       (frz),
    .mem_done_o     (dn)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_stall_cnt_o  (lu_c),
    .flush_cnt_o     (fl_c),
    .mem_stall_cnt_o (ms_c)
`endif
  );

  hazard_stall_ctrl #(.MEM_LAT(1), .CNT_W(4)) dut1 (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (mr),
    .IDEX_rt_i      (xrt),
    .IFID_rs_i      (rs),
    .IFID_rt_i      (rt),
    .Branch_taken_i (br),
    .mem_req_i      (req),
    .PCWrite_o      (pcw1),
    .IFIDWrite_o    (ifw1),
    .IFIDFlush_o    (fl1),
    .Bubble_o       (bub1),
    .Freeze_o       (frz1),
    .mem_done_o     (dn1)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_stall_cnt_o  (lu_c1),
    .flush_cnt_o     (fl_c1),
    .mem_stall_cnt_o (ms_c1)
`endif
  );

  assign out0 = {pcw, ifw, fl, bub, frz, dn};
  assign out1 = {pcw1, ifw1, fl1, bub1, frz1, dn1};

  typedef struct {
    string      nm;
    logic       rst;
    logic       mr;
    logic [4:0] xrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic r,
                     input logic m, input logic [4:0] x,
                     input logic [4:0] s, input logic [4:0] t,
                     input logic b, input logic [5:0] e);
    vec_t v;
    v.nm = nm; v.rst = r; v.mr = m; v.xrt = x;
    v.rs = s; v.rt = t; v.br = b; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [5:0] got,
                       input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Outputs order: PCWrite IFIDWrite Flush Bubble Freeze Done
  function automatic logic [5:0] model_out();
    logic hz;
    hz = mr && (xrt != 5'd0) && (xrt == rs || xrt == rt);
    if (rst_i)     return 6'b000110;
    if (fleft > 0) return (fleft == 1) ? 6'b000011 : 6'b000010;
    if (req)       return (LAT == 1) ? 6'b000011 : 6'b000010;
    if (hz)        return 6'b000100;
    if (br)        return 6'b111000;
    return 6'b110000;
  endfunction

  function automatic void model_next();
    if (rst_i)          fleft = 0;
    else if (fleft > 0) fleft = fleft - 1;
    else if (req)       fleft = LAT - 1;
  endfunction

  task automatic step(input string nm, input logic [5:0] exp);
    #1;
    check(nm, out0, exp);
    @(posedge clk_i);
    model_next();
    @(negedge clk_i);
  endtask

  task automatic step_model(input string nm);
    #1;
    check(nm, out0, model_out());
    @(posedge clk_i);
    model_next();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; mr = 1'b0; xrt = '0; rs = '0; rt = '0;
    br = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset_out", out0, 6'b000110);
    @(negedge clk_i);
    rst_i = 1'b0;
    fleft = 0;
    step("post_rst", 6'b110000);

    add("lu_rs",     0, 1, 5'd8, 5'd8, 5'd3, 0, 6'b000100);
    add("lu_clear",  0, 0, 5'd8, 5'd8, 5'd3, 0, 6'b110000);
    add("lu_rt",     0, 1, 5'd9, 5'd1, 5'd9, 0, 6'b000100);
    add("zero_reg",  0, 1, 5'd0, 5'd0, 5'd0, 0, 6'b110000);
    add("no_match",  0, 1, 5'd8, 5'd7, 5'd6, 0, 6'b110000);
    add("br_only",   0, 0, 5'd0, 5'd0, 5'd0, 1, 6'b111000);
    add("lu_and_br", 0, 1, 5'd5, 5'd5, 5'd0, 1, 6'b000100);
    add("rst_vec",   1, 1, 5'd5, 5'd5, 5'd0, 1, 6'b000110);
    add("after_rst", 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b110000);
    foreach (tbl[i]) begin
      rst_i = tbl[i].rst; mr = tbl[i].mr; xrt = tbl[i].xrt;
      rs = tbl[i].rs; rt = tbl[i].rt; br = tbl[i].br;
      step(tbl[i].nm, tbl[i].exp);
    end

    // freeze with lu and branch pending, both latencies
    mr = 1; xrt = 5'd8; rs = 5'd8; rt = 5'd0; br = 1; req = 1;
    #1 check("lat1_c0", out1, 6'b000011);
    step("frz_c0", 6'b000010);
    req = 0;
    #1 check("lat1_c1", out1, 6'b000100);
    step("frz_c1", 6'b000010);
    step("frz_c2", 6'b000010);
    step("frz_c3", 6'b000011);
    step("frz_exit_lu", 6'b000100);
    mr = 0;
    step("frz_exit_br", 6'b111000);
    br = 0;
    step("frz_idle", 6'b110000);

    // back-to-back accesses
    req = 1; step("b2b_a0", 6'b000010);
    req = 0; step("b2b_a1", 6'b000010);
    step("b2b_a2", 6'b000010);
    step("b2b_a3", 6'b000011);
    req = 1; step("b2b_b0", 6'b000010);
    req = 0; step("b2b_b1", 6'b000010);
    step("b2b_b2", 6'b000010);
    step("b2b_b3", 6'b000011);
    step("b2b_idle", 6'b110000);

    // reset in second MEM_WAIT cycle
    req = 1; step("rm_c0", 6'b000010);
    req = 0; step("rm_c1", 6'b000010);
    rst_i = 1; step("rm_rst", 6'b000110);
    rst_i = 0;
    for (int k = 0; k < 4; k++) step("rm_after", 6'b110000);

`ifdef HAZARD_PERF_CNT_EN
    check32("ms_cnt_clr", ms_c, 32'd0);
    check32("fl_cnt_0", fl_c, 32'd0);
    br = 1; step("perf_br", 6'b111000);
    br = 0;
    check32("fl_cnt_1", fl_c, 32'd1);
    mr = 1; xrt = 5'd3; rs = 5'd3;
    step("perf_lu", 6'b000100);
    mr = 0;
    check32("lu_cnt_1", lu_c, 32'd1);
`endif

    for (int n = 0; n < 400; n++) begin
      rst_i = ($urandom_range(0, 49) == 0);
      mr    = 1'($urandom_range(0, 1));
      xrt   = 5'($urandom_range(0, 3));
      rs    = 5'($urandom_range(0, 3));
      rt    = 5'($urandom_range(0, 3));
      br    = 1'($urandom_range(0, 1));
      req   = (fleft == 0) && ($urandom_range(0, 5) == 0);
      step_model("rand");
    end
    rst_i = 0; req = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
